// File: rtl/cls16_pipe_pkg.sv
// Shared definitions for the pipelined 16-bit borrow-lookahead subtractor.
// Holds the fixed geometry and the stage-1 payload carried between pipeline registers.
package cls16_pipe_pkg;

   localparam int CLS_WIDTH  = 16;
   localparam int CLS_GROUP  = 4;
   localparam int CLS_NGROUP = 4;

   typedef struct packed {
      logic [CLS_WIDTH-1:0]  p;
      logic [CLS_WIDTH-1:0]  g;
      logic [CLS_NGROUP-1:0] G;
      logic [CLS_NGROUP-1:0] P;
      logic                  c0;
      logic                  a_msb;
      logic                  b_msb;
   } cls_s1_t;

endpackage

// File: rtl/cls16_pipe_bblg4.sv
// 4-bit borrow-lookahead generator: in-group carries plus group generate/propagate.
// Carries are in the add direction (c = not-borrow), since the subtract runs as A + ~B + ~Bin.
module bblg4
   import cls16_pipe_pkg::*;
(
   input  logic [CLS_GROUP-1:0] g,
   input  logic [CLS_GROUP-1:0] p,
   input  logic                 cin,
   output logic [CLS_GROUP-1:0] c,
   output logic                 G,
   output logic                 P
);

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

   assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign P = &p;

endmodule

// File: rtl/cls16_pipe.sv
// Two-stage pipelined 16-bit borrow-lookahead subtractor, D = A - B - Bin, with
// valid/ready handshake; stage 1 registers bit/group PG, stage 2 registers the result.
module cls16_pipe
   import cls16_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Ovf,
   output logic             Zero
);

   if (WIDTH != CLS_WIDTH || GROUP != CLS_GROUP) begin : g_param_check
      $error("cls16_pipe supports only WIDTH=16 and GROUP=4");
   end

   logic s2_load;
   logic vld_p1;
   logic vld_p2;

   assign s2_load  = ~vld_p2 | out_ready;
   assign in_ready = ~vld_p1 | ~vld_p2 | out_ready;

   // Stage 0 -> 1: bit terms of A + ~B and per-group generate/propagate
   logic [WIDTH-1:0]      g_p0;
   logic [WIDTH-1:0]      p_p0;
   logic [CLS_NGROUP-1:0] gg_p0;
   logic [CLS_NGROUP-1:0] gp_p0;
   logic [WIDTH-1:0]      c_p0_unused;
   cls_s1_t               s1_p0;
   cls_s1_t               s1_p1;

   assign g_p0 = A & ~B;
   assign p_p0 = A ^ ~B;

   for (genvar k = 0; k < CLS_NGROUP; k++) begin : g_grp_pg
      bblg4 u_grp_pg (
         .g   (g_p0[CLS_GROUP*k +: CLS_GROUP]),
         .p   (p_p0[CLS_GROUP*k +: CLS_GROUP]),
         .cin (1'b0),
         .c   (c_p0_unused[CLS_GROUP*k +: CLS_GROUP]),
         .G   (gg_p0[k]),
         .P   (gp_p0[k])
      );
   end

   always_comb begin
      s1_p0       = '0;
      s1_p0.p     = p_p0;
      s1_p0.g     = g_p0;
      s1_p0.G     = gg_p0;
      s1_p0.P     = gp_p0;
      s1_p0.c0    = ~Bin;
      s1_p0.a_msb = A[WIDTH-1];
      s1_p0.b_msb = B[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
      end else if (in_ready) begin
         vld_p1 <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (in_ready && in_valid) begin
         s1_p1 <= s1_p0;
      end
   end

   // Stage 1 -> 2: second-level lookahead, in-group carries and result flags
   logic [CLS_NGROUP-1:0] cgrp_p1;
   logic                  gall_p1;
   logic                  pall_p1;
   logic                  c16_p1;
   logic [WIDTH-1:0]      c_p1;
   logic [WIDTH-1:0]      diff_p1;
   logic [CLS_NGROUP-1:0] ig_g_unused;
   logic [CLS_NGROUP-1:0] ig_p_unused;

   bblg4 u_lvl2 (
      .g   (s1_p1.G),
      .p   (s1_p1.P),
      .cin (s1_p1.c0),
      .c   (cgrp_p1),
      .G   (gall_p1),
      .P   (pall_p1)
   );

   assign c16_p1 = gall_p1 | (pall_p1 & s1_p1.c0);

   for (genvar k = 0; k < CLS_NGROUP; k++) begin : g_grp_carry
      bblg4 u_grp_carry (
         .g   (s1_p1.g[CLS_GROUP*k +: CLS_GROUP]),
         .p   (s1_p1.p[CLS_GROUP*k +: CLS_GROUP]),
         .cin (cgrp_p1[k]),
         .c   (c_p1[CLS_GROUP*k +: CLS_GROUP]),
         .G   (ig_g_unused[k]),
         .P   (ig_p_unused[k])
      );
   end

   assign diff_p1 = s1_p1.p ^ c_p1;

   logic [WIDTH-1:0] diff_p2;
   logic             bout_p2;
   logic             ovf_p2;
   logic             zero_p2;

   // Result registers reset to zero so the outputs are never X after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2  <= 1'b0;
         diff_p2 <= '0;
         bout_p2 <= 1'b0;
         ovf_p2  <= 1'b0;
         zero_p2 <= 1'b0;
      end else if (s2_load) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            diff_p2 <= diff_p1;
            bout_p2 <= ~c16_p1;
            ovf_p2  <= (s1_p1.a_msb ^ s1_p1.b_msb) & (diff_p1[WIDTH-1] ^ s1_p1.a_msb);
            zero_p2 <= (diff_p1 == '0);
         end
      end
   end

   assign out_valid = vld_p2;
   assign Diff      = diff_p2;
   assign Bout      = bout_p2;
   assign Ovf       = ovf_p2;
   assign Zero      = zero_p2;

endmodule
